shift_sub_div: RTL and testbench

- Sequential 16-by-8 unsigned divider using restoring shift-subtract, one quotient bit per clock.
- It is the inverse companion of the team's shift-add multiplier and uses the same command style: a start strobe `s`, a 2-bit `op`, an 8-bit data input `in`, and a `done` flag.
- A controller loads the dividend (two bytes) and the divisor, issues RUN, then reads the quotient and remainder when `done` is high.

---
 rtl/shift_sub_div.sv | 141 ++++++++++++++
 tb/tb_shift_sub_div.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_sub_div.sv
// shift_sub_div: 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Commands (strobe s, op) load dividend bytes and divisor, or start a RUN.
// The quotient shifts in through the dividend register, so Q doubles as the
// working dividend while the remainder accumulates in R.
module shift_sub_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [1:0]  op,
  input  logic [7:0]  in,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LDH = 2'b00;
  localparam logic [1:0] OP_LDL = 2'b01;
  localparam logic [1:0] OP_LDB = 2'b10;
  localparam logic [1:0] OP_RUN = 2'b11;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_d;
  logic [7:0]  r_b;
  logic [15:0] r_q;
  logic [7:0]  r_r;
  logic [3:0]  r_cnt;
  logic        r_dbz;

  logic [8:0]  w_t;
  logic [8:0]  w_diff;
  logic        w_ge;
  logic        w_b_zero;

  // Partial remainder with the next dividend bit shifted in, and its trial subtraction.
  assign w_t      = {r_r, r_q[15]};
  assign w_diff   = w_t - {1'b0, r_b};
  assign w_ge     = (w_t >= {1'b0, r_b});
  assign w_b_zero = (r_b == 8'h00);

  assign quot = r_q;
  assign rem  = r_r;
  assign dbz  = r_dbz;
  assign done = (r_state == ST_WAIT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a RUN with a zero divisor is answered in place and stays in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT: begin
        if (s) begin
          if (op != OP_RUN) begin
            w_state_next = ST_LOAD;
          end else if (!w_b_zero) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_LOAD: w_state_next = ST_WAIT;
      ST_RUN: begin
        if (r_cnt == 4'd15) begin
          w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  // Datapath: command handling in WAIT, one restoring step per cycle in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d   <= 16'h0000;
      r_b   <= 8'h00;
      r_q   <= 16'h0000;
      r_r   <= 8'h00;
      r_cnt <= 4'd0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (s) begin
            case (op)
              OP_LDH: begin
                r_d[15:8] <= in;
                r_dbz     <= 1'b0;
              end
              OP_LDL: begin
                r_d[7:0] <= in;
                r_dbz    <= 1'b0;
              end
              OP_LDB: begin
                r_b   <= in;
                r_dbz <= 1'b0;
              end
              default: begin
                if (w_b_zero) begin
                  r_q   <= 16'hFFFF;
                  r_r   <= 8'h00;
                  r_dbz <= 1'b1;
                end else begin
                  r_q   <= r_d;
                  r_r   <= 8'h00;
                  r_cnt <= 4'd0;
                  r_dbz <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_RUN: begin
          if (w_ge) begin
            r_r <= w_diff[7:0];
            r_q <= {r_q[14:0], 1'b1};
          end else begin
            r_r <= w_t[7:0];
            r_q <= {r_q[14:0], 1'b0};
          end
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed bench for shift_sub_div: hand-computed quotients/remainders,
// divide-by-zero, command masking during RUN and asynchronous reset abort.
module tb_shift_sub_div;

  logic        clk;
  logic        reset;
  logic        s;
  logic [1:0]  op;
  logic [7:0]  in;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        done;
  logic        dbz;

  int n_cmp;
  int n_bad;

  shift_sub_div dut (
    .clk  (clk),
    .reset(reset),
    .s    (s),
    .op   (op),
    .in   (in),
    .quot (quot),
    .rem  (rem),
    .done (done),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One-cycle command pulse; returns at the negedge after the accepting edge.
  task automatic cmd(input logic [1:0] c_op, input logic [7:0] c_in);
    @(negedge clk);
    s  = 1'b1;
    op = c_op;
    in = c_in;
    @(negedge clk);
    s  = 1'b0;
  endtask

  // Counts cycles after the RUN accept edge until done rises, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic load_div(input logic [7:0] h, input logic [7:0] l, input logic [7:0] b);
    cmd(2'b00, h);
    cmd(2'b01, l);
    cmd(2'b10, b);
  endtask

  task automatic run_check(input string tag, input logic [15:0] eq, input logic [7:0] er);
    int lat;
    cmd(2'b11, 8'h00);
    check({tag, "_busy"}, {31'd0, done}, 32'd0);
    wait_done(lat);
    check({tag, "_lat"}, lat, 32'd16);
    check({tag, "_quot"}, {16'd0, quot}, {16'd0, eq});
    check({tag, "_rem"}, {24'd0, rem}, {24'd0, er});
    check({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_bad = 0;
    s     = 1'b0;
    op    = 2'b00;
    in    = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd1);
    check("rst_quot", {16'd0, quot}, 32'd0);
    check("rst_rem",  {24'd0, rem},  32'd0);
    check("rst_dbz",  {31'd0, dbz},  32'd0);

    // 1000 / 7 = 142 r 6; LOAD state drops done for one cycle
    cmd(2'b00, 8'h03);
    check("load_ack_done", {31'd0, done}, 32'd0);
    cmd(2'b01, 8'hE8);
    cmd(2'b10, 8'h07);
    run_check("d1000_7", 16'h008E, 8'h06);

    // 65535 / 255 = 257 r 0, then repeat without reload
    load_div(8'hFF, 8'hFF, 8'hFF);
    run_check("dffff_ff", 16'h0101, 8'h00);
    run_check("dffff_ff_rep", 16'h0101, 8'h00);

    // dividend smaller than divisor
    load_div(8'h00, 8'h05, 8'h09);
    run_check("d5_9", 16'h0000, 8'h05);

    // divide by zero answers immediately and stays in WAIT
    cmd(2'b10, 8'h00);
    cmd(2'b11, 8'h00);
    check("dbz_flag", {31'd0, dbz},  32'd1);
    check("dbz_quot", {16'd0, quot}, 32'h0000FFFF);
    check("dbz_rem",  {24'd0, rem},  32'd0);
    check("dbz_done", {31'd0, done}, 32'd1);
    cmd(2'b10, 8'h03);
    check("dbz_clear", {31'd0, dbz}, 32'd0);

    // command pulsed during RUN is ignored
    load_div(8'h03, 8'hE8, 8'h07);
    cmd(2'b11, 8'h00);
    repeat (4) @(negedge clk);
    s  = 1'b1;
    op = 2'b10;
    in = 8'h02;
    @(negedge clk);
    s  = 1'b0;
    wait_done(lat);
    check("ign_lat",  lat + 5, 32'd16);
    check("ign_quot", {16'd0, quot}, 32'h0000008E);
    check("ign_rem",  {24'd0, rem},  32'd6);
    // B must still be 7: a second RUN gives the same answer
    run_check("ign_rerun", 16'h008E, 8'h06);

    // asynchronous reset mid-RUN
    cmd(2'b11, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_quot", {16'd0, quot}, 32'd0);
    check("arst_rem",  {24'd0, rem},  32'd0);
    check("arst_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    cmd(2'b11, 8'h00);
    check("arst_dbz",      {31'd0, dbz},  32'd1);
    check("arst_dbz_quot", {16'd0, quot}, 32'h0000FFFF);
    check("arst_dbz_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
